ibex_fp_regfile: RTL

IBEX_FP_REGFILE -- requirements
Module: ibex_fp_regfile

---
 rtl/ibex_fp_regfile.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ibex_fp_regfile.sv
`default_nettype none
// ============================================================================
// Module      : ibex_fp_regfile
// Description : 32 x 32-bit floating-point register file with three
//               combinational read ports, FPU-over-LSU write arbitration,
//               a one-entry pending buffer for colliding load writes and
//               sticky accumulated exception flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_fp_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fpu_we_i,
  input  logic [4:0]  fpu_waddr_i,
  input  logic [31:0] fpu_wdata_i,
  input  logic [4:0]  fpu_flags_i,
  input  logic        lsu_we_i,
  input  logic [4:0]  lsu_waddr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  input  logic [4:0]  raddr_c_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o,
  output logic [31:0] rdata_c_o,
  input  logic        fflags_clr_i,
  output logic [4:0]  fflags_o
);

  localparam int NUM_REGS = 32;
  localparam int NUM_RPORTS = 3;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_t;

  state_t      state;
  logic [4:0]  buf_addr;
  logic [31:0] buf_data;
  logic [31:0] regs [NUM_REGS];

  logic        lsu_accept;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  logic [4:0]  raddr [NUM_RPORTS];
  logic [31:0] rdata [NUM_RPORTS];

  // Ready depends on state only, so the load unit never sees a comb loop.
  assign lsu_ready_o = (state == EMPTY);
  assign lsu_accept  = lsu_we_i & lsu_ready_o;

  // Select the single array write for this cycle. At most one source can
  // target the array per cycle: loads are refused while the buffer is held,
  // and a held buffer only drains in cycles without an FPU write.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = fpu_waddr_i;
    wr_data = fpu_wdata_i;
    if (fpu_we_i) begin
      wr_en = 1'b1;
    end else if (state == HELD) begin
      wr_en   = 1'b1;
      wr_addr = buf_addr;
      wr_data = buf_data;
    end else if (lsu_accept) begin
      wr_en   = 1'b1;
      wr_addr = lsu_waddr_i;
      wr_data = lsu_wdata_i;
    end
  end

  // Pending-buffer state machine: capture a load that loses arbitration,
  // drain it on the first free cycle, drop it if the FPU overwrites it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= EMPTY;
      buf_addr <= '0;
      buf_data <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (lsu_accept && fpu_we_i) begin
            state    <= HELD;
            buf_addr <= lsu_waddr_i;
            buf_data <= lsu_wdata_i;
          end
        end
        HELD: begin
          if (!fpu_we_i || (fpu_waddr_i == buf_addr)) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Register array update; reset clears every entry including f0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Sticky exception flags; a clear in the same cycle as an FPU write keeps
  // only the new flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_o <= '0;
    end else if (fflags_clr_i) begin
      fflags_o <= fpu_we_i ? fpu_flags_i : 5'b0;
    end else if (fpu_we_i) begin
      fflags_o <= fflags_o | fpu_flags_i;
    end
  end

  assign raddr[0]  = raddr_a_i;
  assign raddr[1]  = raddr_b_i;
  assign raddr[2]  = raddr_c_i;
  assign rdata_a_o = rdata[0];
  assign rdata_b_o = rdata[1];
  assign rdata_c_o = rdata[2];

  // Each read port forwards the newest value: FPU write, then held load,
  // then accepted load, then the stored array contents.
  generate
    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_read
      always_comb begin
        if (fpu_we_i && (fpu_waddr_i == raddr[p])) begin
          rdata[p] = fpu_wdata_i;
        end else if ((state == HELD) && (buf_addr == raddr[p])) begin
          rdata[p] = buf_data;
        end else if (lsu_accept && (lsu_waddr_i == raddr[p])) begin
          rdata[p] = lsu_wdata_i;
        end else begin
          rdata[p] = regs[raddr[p]];
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire
